async_req_arbiter: RTL
======================

// Module: async_req_arbiter
// PURPOSE
//  Collects NUM_REQ asynchronous request lines and synchronizes each through two flops.
//  Rising edges are latched as pending requests. A round-robin arbiter grants one shared
//  service resource at a time, with a grant/done handshake and a timeout abort. It sits
//  between off-chip/button-style async inputs and a single shared datapath (e.g. flex counter).
// PARAMETERS
//  NUM_REQ      4    number of async requesters (2..16)
//  TIMEOUT_CYC  16   max cycles a grant is held without done before forced release (>=2)
//  ID_W         $clog2(NUM_REQ)  width of grant_id (derived, not overridden)
// PORTS
//  clk          in   1        system clock, all logic on posedge
//  n_rst        in   1        reset; synchronous, active-low
//  async_req    in   NUM_REQ  asynchronous request lines, level, rising edge = new request
//  done         in   1        shared resource finished current grant (1-cycle pulse or level)
//  grant        out  NUM_REQ  one-hot grant, held while serving; 0 otherwise
//  grant_id     out  ID_W     index of granted requester; 0 when no grant
//  busy         out  1        1 in GRANT or RELEASE state
//  pending      out  NUM_REQ  latched, not-yet-granted requests
//  timeout_err  out  1        1-cycle pulse when a grant is aborted by timeout
// BEHAVIOUR
//  Reset (n_rst=0 at posedge): sync flops, edge flops, pending, grant, grant_id, busy,
//   timeout_err, timeout counter all 0; state=IDLE; RR pointer=0. Applies mid-grant too:
//   grant drops at the reset edge, and no timeout_err is issued.
//  Sync/edge: per line, s1<=async_req, s2<=s1, s3<=s2; rise=s2&~s3.
//   Async high sampled at edge E0 -> pending bit set at E2 -> grant visible after E3.
//  Pending: set on rise; cleared only when that id is granted (IDLE->GRANT edge).
//   A set and a clear on the same id at the same edge: set wins, so the request stays queued.
//   A rise on an already-pending id is absorbed, with no second entry.
//  FSM states: IDLE, GRANT, RELEASE.
//   IDLE: if pending!=0, choose the first set bit at or after RR pointer (wrap NUM_REQ-1->0);
//     go to GRANT, drive grant/grant_id, clear the counter. Otherwise stay.
//   GRANT: counter+1 per cycle.
//     If done=1 -> RELEASE.
//     Else if counter==TIMEOUT_CYC-1 -> RELEASE and pulse timeout_err.
//     done and timeout in the same cycle: done wins, no error.
//   RELEASE: exactly one cycle. grant=0, busy=1, RR pointer<=grant_id+1 (mod NUM_REQ).
//     Then -> IDLE.
//  Min gap between grants: 1 RELEASE + 1 IDLE cycle. done outside GRANT is ignored.
//  All outputs are registered; grant is never multi-hot.
// STRUCTURE
//  arb_pkg: typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t.
//   Also localparam helpers for counter width ($clog2(TIMEOUT_CYC)).
//  Sub-module req_sync_edge (one per line via generate): 3 flops, sync active-low reset,
//   outputs rise pulse. The top holds pending regs, RR selection, FSM and counter.
// TESTING
//  1 Reset: drive random async_req with n_rst=0 for 3 cycles -> all outputs 0, state IDLE.
//  2 Latency: async_req=4'b0100 raised before E0 -> pending[2]=1 after E2, grant=4'b0100,
//    grant_id=2 after E3; done at E5 -> grant=0 at E6, busy=0 at E7.
//  3 Round robin: all 4 requests rise together, done 2 cycles after each grant ->
//    grant order 0,1,2,3; reraise all -> order 0,1,2,3 again (pointer wraps).
//  4 Timeout: grant id 1, never assert done -> grant held 16 cycles, timeout_err high
//    for 1 cycle at release, pending[1]=0; done and timeout on same cycle -> no err.
//  5 Requeue: while id 0 is granted, re-raise async_req[0] -> pending[0]=1, and it is
//    granted again only after the other pending ids (RR fairness).
//  6 Reset mid-grant: n_rst=0 during GRANT -> grant=0, pending=0 next edge, no err pulse.

Source files
------------

// File: rtl/async_req_arbiter_pkg.sv
// Shared types and sizing helpers for the async request arbiter.
package async_req_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // Timeout counter width; it only ever has to reach TIMEOUT_CYC-1.
    function automatic int cnt_width(input int timeout_cyc);
        return (timeout_cyc <= 2) ? 1 : $clog2(timeout_cyc);
    endfunction

endpackage

// File: rtl/async_req_arbiter_req_sync_edge.sv
// Two-flop synchronizer plus edge flop for one async line; rise is a 1-cycle pulse 2 cycles after capture.
// No backpressure: a rise is a pulse and the consumer must latch it.
module async_req_arbiter_req_sync_edge (
    input  logic clk,
    input  logic n_rst,
    input  logic line,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= line;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/async_req_arbiter.sv
// Round-robin grant of one shared resource to synchronized async requesters; pending after 3 edges, grant after 4.
// Requests queue in pending while the resource is busy; a held grant is forced off after TIMEOUT_CYC cycles.
module async_req_arbiter
    import async_req_arbiter_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int TIMEOUT_CYC = 16,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [NUM_REQ-1:0] async_req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy,
    output logic [NUM_REQ-1:0] pending,
    output logic               timeout_err
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    arb_state_t           state;
    arb_state_t           state_nxt;
    logic [NUM_REQ-1:0]   rise;
    logic [CNT_W-1:0]     cnt;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      cur_id;
    logic                 sel_found;
    logic [ID_W-1:0]      sel_id;
    logic [ID_W-1:0]      idx;
    logic [NUM_REQ-1:0]   pend_clr;
    logic                 hit_timeout;
    logic [NUM_REQ-1:0]   grant_nxt;
    logic [ID_W-1:0]      grant_id_nxt;
    logic                 busy_nxt;
    logic                 timeout_err_nxt;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_sync
        async_req_arbiter_req_sync_edge u_sync (
            .clk   (clk),
            .n_rst (n_rst),
            .line  (async_req[g]),
            .rise  (rise[g])
        );
    end

    // First pending bit at or after the round-robin pointer, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!sel_found && pending[idx]) begin
                sel_found = 1'b1;
                sel_id    = idx;
            end
        end
    end

    assign hit_timeout = (cnt == CNT_LAST);
    assign pend_clr    = (state == IDLE && sel_found) ? (NUM_REQ'(1) << sel_id) : '0;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            grant_id    <= grant_id_nxt;
            busy        <= busy_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_found) state_nxt = GRANT;
            GRANT:   if (done || hit_timeout) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; done takes priority over timeout.
    always_comb begin
        grant_nxt       = '0;
        grant_id_nxt    = '0;
        busy_nxt        = 1'b0;
        timeout_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    grant_nxt    = NUM_REQ'(1) << sel_id;
                    grant_id_nxt = sel_id;
                    busy_nxt     = 1'b1;
                end
            end
            GRANT: begin
                busy_nxt = 1'b1;
                if (done) begin
                    timeout_err_nxt = 1'b0;
                end else if (hit_timeout) begin
                    timeout_err_nxt = 1'b1;
                end else begin
                    grant_nxt    = grant;
                    grant_id_nxt = grant_id;
                end
            end
            default: begin
                grant_nxt = '0;
            end
        endcase
    end

    // Set wins over clear so a re-raise during the granting edge stays queued.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            pending <= '0;
            cnt     <= '0;
            rr_ptr  <= '0;
            cur_id  <= '0;
        end else begin
            pending <= (pending & ~pend_clr) | rise;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (sel_found) cur_id <= sel_id;
                end
                GRANT: begin
                    cnt <= cnt + CNT_W'(1);
                end
                RELEASE: begin
                    cnt    <= '0;
                    rr_ptr <= (cur_id == ID_LAST) ? '0 : cur_id + ID_W'(1);
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule
